sa_skew_feeder: RTL

- Upstream stage of the systolic array. Buffers one tile: K_LEN input-x column vectors and K_LEN weight row vectors.
- Drives the array's left (x) and top (w) edges with diagonal skew and zero padding.
- Issues the array start pulse and steps the feed on each array shift pulse.
- Signals O_DONE when the last operand pair has reached PE[SA_R-1][SA_C-1].

---
 rtl/sa_skew_feeder.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/sa_skew_feeder.sv
// sa_skew_feeder: buffers one K_LEN-deep tile of x columns and w rows, then
// drives the systolic array's left/top edges with diagonal skew, stepping
// once per array shift pulse and pulsing O_DONE after the drain completes.
module sa_skew_feeder #(
   parameter int D_W   = 16,
   parameter int SA_R  = 16,
   parameter int SA_C  = 16,
   parameter int K_LEN = 16
) (
   input  logic                  I_CLK,
   input  logic                  I_ASYN_RSTN,
   input  logic                  I_SYNC_RSTN,
   input  logic                  I_VLD,
   output logic                  O_RDY,
   input  logic [SA_R*D_W-1:0]   I_X_COL,
   input  logic [SA_C*D_W-1:0]   I_W_ROW,
   input  logic                  I_SHIFT,
   output logic                  O_START_FLAG,
   output logic [SA_R*D_W-1:0]   O_X,
   output logic [SA_C*D_W-1:0]   O_W,
   output logic                  O_BUSY,
   output logic                  O_DONE
);

   // Total feed steps, including the all-zero drain that flushes the array.
   localparam int T    = K_LEN + SA_R + SA_C - 2;
   localparam int ST_W = $clog2(T + 1);
   localparam int KI_W = (K_LEN > 1) ? $clog2(K_LEN) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FEED, S_DONE} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [KI_W-1:0]       r_ld_cnt;
   logic [ST_W-1:0]       r_step;
   logic                  r_start;
   logic [SA_R*D_W-1:0]   r_x;
   logic [SA_C*D_W-1:0]   r_w;

   // Tile buffers: one packed vector per inner-dimension index k.
   logic [SA_R*D_W-1:0]   r_xbuf [K_LEN];
   logic [SA_C*D_W-1:0]   r_wbuf [K_LEN];

   logic                  w_beat;
   logic [KI_W-1:0]       w_wr_idx;
   logic                  w_load_done;
   logic                  w_step_adv;
   logic                  w_feed_last;
   logic [ST_W-1:0]       w_tgt;
   logic [D_W-1:0]        w_x0;
   logic [D_W-1:0]        w_w0;
   logic [SA_R*D_W-1:0]   w_x_nxt;
   logic [SA_C*D_W-1:0]   w_w_nxt;

   assign w_beat      = I_VLD & O_RDY;
   assign w_wr_idx    = (r_state == S_IDLE) ? '0 : r_ld_cnt;
   assign w_load_done = w_beat && (int'(w_wr_idx) == K_LEN - 1);
   assign w_step_adv  = (r_state == S_FEED) && I_SHIFT;
   assign w_feed_last = w_step_adv && (int'(r_step) == T - 1);

   // Step whose values are loaded at the next edge: 0 when entering FEED,
   // t+1 when a shift arrives during FEED.
   assign w_tgt = (r_state == S_FEED) ? (r_step + ST_W'(1)) : '0;

   // Step 0 only uses element [0][0]; when K_LEN == 1 it is being written
   // at the same edge, so bypass the incoming beat.
   assign w_x0 = (w_beat && (w_wr_idx == '0)) ? I_X_COL[D_W-1:0] : r_xbuf[0][D_W-1:0];
   assign w_w0 = (w_beat && (w_wr_idx == '0)) ? I_W_ROW[D_W-1:0] : r_wbuf[0][D_W-1:0];

   // Lane i of x at step t carries x[i][t-i]; zero outside the tile.
   for (genvar gi = 0; gi < SA_R; gi++) begin : g_x_lane
      int w_d;
      assign w_d = int'(w_tgt) - gi;
      assign w_x_nxt[gi*D_W +: D_W] =
         (w_d >= 0 && w_d < K_LEN) ?
            ((gi == 0 && w_d == 0) ? w_x0 : r_xbuf[w_d[KI_W-1:0]][gi*D_W +: D_W]) :
            '0;
   end

   // Lane j of w at step t carries w[t-j][j]; zero outside the tile.
   for (genvar gj = 0; gj < SA_C; gj++) begin : g_w_lane
      int w_d;
      assign w_d = int'(w_tgt) - gj;
      assign w_w_nxt[gj*D_W +: D_W] =
         (w_d >= 0 && w_d < K_LEN) ?
            ((gj == 0 && w_d == 0) ? w_w0 : r_wbuf[w_d[KI_W-1:0]][gj*D_W +: D_W]) :
            '0;
   end

   // State register with async and sync reset.
   always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
      if (!I_ASYN_RSTN)      r_state <= S_IDLE;
      else if (!I_SYNC_RSTN) r_state <= S_IDLE;
      else                   r_state <= w_state_nxt;
   end

   // Next-state logic and state-decoded handshake/status outputs.
   always_comb begin
      w_state_nxt = r_state;
      O_RDY       = 1'b0;
      O_BUSY      = 1'b0;
      O_DONE      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            O_RDY = 1'b1;
            if (w_load_done)  w_state_nxt = S_FEED;
            else if (w_beat)  w_state_nxt = S_LOAD;
         end
         S_LOAD: begin
            O_RDY = 1'b1;
            if (w_load_done)  w_state_nxt = S_FEED;
         end
         S_FEED: begin
            O_BUSY = 1'b1;
            if (w_feed_last)  w_state_nxt = S_DONE;
         end
         S_DONE: begin
            O_DONE      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Load index and feed step counters.
   always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
      if (!I_ASYN_RSTN) begin
         r_ld_cnt <= '0;
         r_step   <= '0;
      end else if (!I_SYNC_RSTN) begin
         r_ld_cnt <= '0;
         r_step   <= '0;
      end else begin
         if (w_load_done)  r_ld_cnt <= '0;
         else if (w_beat)  r_ld_cnt <= w_wr_idx + KI_W'(1);
         if (r_state != S_FEED) r_step <= '0;
         else if (w_step_adv)   r_step <= r_step + ST_W'(1);
      end
   end

   // Edge feed registers and the one-cycle start pulse.
   always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
      if (!I_ASYN_RSTN) begin
         r_start <= 1'b0;
         r_x     <= '0;
         r_w     <= '0;
      end else if (!I_SYNC_RSTN) begin
         r_start <= 1'b0;
         r_x     <= '0;
         r_w     <= '0;
      end else begin
         r_start <= w_load_done;
         if (w_feed_last) begin
            r_x <= '0;
            r_w <= '0;
         end else if (w_load_done || w_step_adv) begin
            r_x <= w_x_nxt;
            r_w <= w_w_nxt;
         end
      end
   end

   // Tile storage; contents are don't-care after reset, so no reset here.
   always_ff @(posedge I_CLK) begin
      if (w_beat) begin
         r_xbuf[w_wr_idx] <= I_X_COL;
         r_wbuf[w_wr_idx] <= I_W_ROW;
      end
   end

   assign O_START_FLAG = r_start;
   assign O_X          = r_x;
   assign O_W          = r_w;

endmodule
